// File: rtl/skeleton_result_packer_if.sv
// Packer-side bundle: skeleton capture inputs, byte-stream handshake and status.
// The source/sink side takes master, the packer takes slave.
interface skeleton_result_packer_if #(
  parameter int BITWIDTH_SYS  = 16,
  parameter int BITWIDTH_HEAD = 32,
  parameter int FIFO_DEPTH    = 8
);
  localparam int LEVEL_W = $clog2(FIFO_DEPTH) + 1;

  logic                     EN;
  logic                     START_FLAG;
  logic [BITWIDTH_SYS-1:0]  DATA_IN;
  logic [BITWIDTH_HEAD-7:0] DATA_HEAD_IN;
  logic                     DATA_VALID_IN;
  logic [7:0]               TX_DATA;
  logic                     TX_VALID;
  logic                     TX_READY;
  logic [LEVEL_W-1:0]       FIFO_LEVEL;
  logic                     OVERFLOW;

  modport master (
    output EN, START_FLAG, DATA_IN, DATA_HEAD_IN, DATA_VALID_IN, TX_READY,
    input  TX_DATA, TX_VALID, FIFO_LEVEL, OVERFLOW
  );

  modport slave (
    input  EN, START_FLAG, DATA_IN, DATA_HEAD_IN, DATA_VALID_IN, TX_READY,
    output TX_DATA, TX_VALID, FIFO_LEVEL, OVERFLOW
  );
endinterface

// File: rtl/skeleton_result_packer.sv
// Buffers skeleton result words in a FIFO and serialises them as bytes, inserting
// a 0xA5 + 4-byte header frame after every START_FLAG.
module skeleton_result_packer #(
  parameter int BITWIDTH_SYS  = 16,
  parameter int BITWIDTH_HEAD = 32,
  parameter int FIFO_DEPTH    = 8
) (
  input  logic                    CLK_SYS,
  input  logic                    RST,
  skeleton_result_packer_if.slave bus
);
  localparam int BYTES     = BITWIDTH_SYS / 8;
  localparam int PTR_W     = $clog2(FIFO_DEPTH);
  localparam int LEVEL_W   = PTR_W + 1;
  localparam int HEAD_W    = BITWIDTH_HEAD - 6;
  localparam int IDX_W     = ($clog2(BYTES) > 2) ? $clog2(BYTES) : 2;
  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [1:0] {ST_IDLE, ST_SYNC, ST_HEAD, ST_WORD} state_t;

  state_t                  state_reg, state_next;
  logic [IDX_W-1:0]        idx_reg, idx_next;
  logic                    hdr_pending_reg, hdr_pending_next;
  logic                    hdr_clear;
  logic [HEAD_W-1:0]       head_reg;
  logic [BITWIDTH_SYS-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr_reg, rd_ptr_reg;
  logic [LEVEL_W-1:0]      level_reg;
  logic                    overflow_reg;

  logic                    tx_valid;
  logic [7:0]              tx_data;
  logic                    handshake;
  logic                    fifo_empty, fifo_full;
  logic                    push_req, push_ok, pop;
  logic                    last_word_byte;
  logic                    words_after_pop;
  logic [BITWIDTH_SYS-1:0] fifo_head;
  logic [31:0]             hdr_word;
  logic [7:0]              hdr_byte  [4];
  logic [7:0]              word_byte [BYTES];

  // FIFO control
  assign fifo_empty     = (level_reg == '0);
  assign fifo_full      = (level_reg == LEVEL_W'(FIFO_DEPTH));
  assign tx_valid       = (state_reg != ST_IDLE);
  assign handshake      = tx_valid && bus.TX_READY;
  assign last_word_byte = (state_reg == ST_WORD) && (idx_reg == IDX_W'(BYTES - 1));
  assign pop            = handshake && last_word_byte;
  assign push_req       = bus.EN && bus.DATA_VALID_IN && !bus.START_FLAG;
  // A full FIFO still accepts a word when the head is leaving on this same edge.
  assign push_ok        = push_req && (!fifo_full || pop);
  assign words_after_pop = (level_reg > LEVEL_W'(1)) || push_ok;

  // The head word is read combinationally so the byte mux sees it without a bubble.
  assign fifo_head = mem[rd_ptr_reg];
  assign hdr_word  = {{(32 - HEAD_W){1'b0}}, head_reg};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_hdr_bytes
      assign hdr_byte[gi] = hdr_word[31 - 8*gi -: 8];
    end
    for (gi = 0; gi < BYTES; gi++) begin : g_word_bytes
      assign word_byte[gi] = fifo_head[BITWIDTH_SYS - 1 - 8*gi -: 8];
    end
  endgenerate

  // FSM state register
  always_ff @(posedge CLK_SYS or posedge RST) begin
    if (RST) begin
      state_reg       <= ST_IDLE;
      idx_reg         <= '0;
      hdr_pending_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      idx_reg         <= idx_next;
      hdr_pending_reg <= hdr_pending_next;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    hdr_clear  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (hdr_pending_reg || bus.START_FLAG) begin
          state_next = ST_SYNC;
          idx_next   = '0;
        end else if (!fifo_empty) begin
          state_next = ST_WORD;
          idx_next   = '0;
        end
      end
      ST_SYNC: begin
        if (handshake) begin
          state_next = ST_HEAD;
          idx_next   = '0;
        end
      end
      ST_HEAD: begin
        if (handshake) begin
          if (idx_reg == IDX_W'(3)) begin
            hdr_clear  = 1'b1;
            idx_next   = '0;
            state_next = fifo_empty ? ST_IDLE : ST_WORD;
          end else begin
            idx_next = idx_reg + IDX_W'(1);
          end
        end
      end
      ST_WORD: begin
        if (handshake) begin
          if (last_word_byte) begin
            idx_next = '0;
            if (hdr_pending_reg)      state_next = ST_SYNC;
            else if (words_after_pop) state_next = ST_WORD;
            else                      state_next = ST_IDLE;
          end else begin
            idx_next = idx_reg + IDX_W'(1);
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
        idx_next   = '0;
      end
    endcase
  end

  // A new START_FLAG wins over the clear at the end of a header frame.
  always_comb begin
    hdr_pending_next = hdr_pending_reg;
    if (bus.START_FLAG)  hdr_pending_next = 1'b1;
    else if (hdr_clear)  hdr_pending_next = 1'b0;
  end

  // FSM output logic
  always_comb begin
    tx_data = 8'h00;
    case (state_reg)
      ST_SYNC: tx_data = SYNC_BYTE;
      ST_HEAD: begin
        for (int i = 0; i < 4; i++) begin
          if (idx_reg == IDX_W'(i)) tx_data = hdr_byte[i];
        end
      end
      ST_WORD: begin
        for (int i = 0; i < BYTES; i++) begin
          if (idx_reg == IDX_W'(i)) tx_data = word_byte[i];
        end
      end
      default: tx_data = 8'h00;
    endcase
  end

  // Pointers, level, header latch and sticky overflow
  always_ff @(posedge CLK_SYS or posedge RST) begin
    if (RST) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      level_reg    <= '0;
      head_reg     <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)     rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({push_ok, pop})
        2'b10:   level_reg <= level_reg + LEVEL_W'(1);
        2'b01:   level_reg <= level_reg - LEVEL_W'(1);
        default: level_reg <= level_reg;
      endcase
      if (bus.START_FLAG) begin
        head_reg     <= bus.DATA_HEAD_IN;
        overflow_reg <= 1'b0;
      end else if (push_req && !push_ok) begin
        overflow_reg <= 1'b1;
      end
    end
  end

  always_ff @(posedge CLK_SYS) begin
    if (push_ok) mem[wr_ptr_reg] <= bus.DATA_IN;
  end

  assign bus.TX_VALID   = tx_valid;
  assign bus.TX_DATA    = tx_data;
  assign bus.FIFO_LEVEL = level_reg;
  assign bus.OVERFLOW   = overflow_reg;

endmodule

// File: tb/tb_skeleton_result_packer.sv
// Randomised + directed bench for skeleton_result_packer with a queue-based frame model.
module tb_skeleton_result_packer;
  localparam int SYS   = 16;
  localparam int HEADW = 32;
  localparam int DEPTH = 8;
  localparam int BYTES = SYS / 8;

  logic clk;
  logic rst;

  skeleton_result_packer_if #(.BITWIDTH_SYS(SYS), .BITWIDTH_HEAD(HEADW), .FIFO_DEPTH(DEPTH)) bus ();

  skeleton_result_packer #(.BITWIDTH_SYS(SYS), .BITWIDTH_HEAD(HEADW), .FIFO_DEPTH(DEPTH)) dut (
    .CLK_SYS(clk),
    .RST    (rst),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Model: FIFO of words, current frame as a queue of byte tokens.
  // Tokens < 256 are literal bytes; 256 is the sync byte; 257..260 are header bytes.
  logic [SYS-1:0] words [$];
  int             cur [$];
  bit             cur_word;
  bit             m_hdr;
  logic [31:0]    m_head;
  bit             m_ovf;
  int             log_q [$];

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int tok_byte(input int tok);
    if (tok < 256) return tok;
    if (tok == 256) return 8'hA5;
    return int'(m_head[8*(260 - tok) +: 8]);
  endfunction

  task automatic start_hdr();
    cur.delete();
    for (int t = 256; t <= 260; t++) cur.push_back(t);
    cur_word = 0;
  endtask

  task automatic start_word();
    logic [SYS-1:0] w;
    w = words[0];
    cur.delete();
    for (int b = 0; b < BYTES; b++) cur.push_back(int'((w >> (8*(BYTES-1-b))) & 'hFF));
    cur_word = 1;
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      words.delete(); cur.delete();
      cur_word = 0; m_hdr = 0; m_head = 0; m_ovf = 0;
    end else begin : step
      bit valid, hs, fin, was_word, pop, push, push_ok, hdr_done;
      int lvl_pre;
      valid    = cur.size() != 0;
      hs       = valid && bus.TX_READY;
      fin      = hs && cur.size() == 1;
      was_word = cur_word;
      pop      = fin && was_word;
      push     = bus.EN && bus.DATA_VALID_IN && !bus.START_FLAG;
      push_ok  = push && (words.size() < DEPTH || pop);
      lvl_pre  = words.size();
      hdr_done = fin && !was_word;
      if (pop) void'(words.pop_front());
      if (push_ok) words.push_back(bus.DATA_IN);
      if (hs) void'(cur.pop_front());
      if (!valid) begin
        if (m_hdr || bus.START_FLAG) start_hdr();
        else if (lvl_pre > 0) start_word();
      end else if (fin) begin
        if (was_word && m_hdr) start_hdr();
        else if (was_word ? (words.size() > 0) : (lvl_pre > 0)) start_word();
      end
      if (bus.START_FLAG) begin
        m_hdr = 1; m_head = 32'(bus.DATA_HEAD_IN); m_ovf = 0;
      end else begin
        if (hdr_done) m_hdr = 0;
        if (push && !push_ok) m_ovf = 1;
      end
    end
  end

  // Compare process: every cycle, away from the active edge
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      check("tx_valid", int'(bus.TX_VALID), int'(cur.size() != 0));
      if (cur.size() != 0) check("tx_data", int'(bus.TX_DATA), tok_byte(cur[0]));
      check("fifo_level", int'(bus.FIFO_LEVEL), words.size());
      check("overflow", int'(bus.OVERFLOW), int'(m_ovf));
      if (bus.TX_VALID && bus.TX_READY) log_q.push_back(int'(bus.TX_DATA));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic expect_log(input string name, input int exp_q[$]);
    check({name, "_len"}, log_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
      check($sformatf("%s_b%0d", name, i), log_q[i], exp_q[i]);
  endtask

  initial begin
    int exp_q [$];
    int n;
    int ready_pct;
    rst = 1'b1;
    bus.EN = 0; bus.START_FLAG = 0; bus.DATA_IN = '0; bus.DATA_HEAD_IN = '0;
    bus.DATA_VALID_IN = 0; bus.TX_READY = 0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("rst_valid", int'(bus.TX_VALID), 0);
    check("rst_data", int'(bus.TX_DATA), 0);
    check("rst_level", int'(bus.FIFO_LEVEL), 0);
    check("rst_ovf", int'(bus.OVERFLOW), 0);

    // Header frame
    tick();
    bus.TX_READY = 1; bus.DATA_HEAD_IN = 26'h0104210; bus.START_FLAG = 1;
    log_q.delete();
    tick();
    bus.START_FLAG = 0;
    repeat (7) tick();
    exp_q = '{'hA5, 'h00, 'h10, 'h42, 'h10};
    expect_log("hdr", exp_q);
    check("hdr_idle", int'(bus.TX_VALID), 0);

    // Two-word stream
    log_q.delete();
    bus.EN = 1; bus.DATA_VALID_IN = 1; bus.DATA_IN = 16'h1234;
    tick();
    bus.DATA_IN = 16'hABCD;
    tick();
    bus.DATA_VALID_IN = 0;
    repeat (8) tick();
    exp_q = '{'h12, 'h34, 'hAB, 'hCD};
    expect_log("stream", exp_q);
    check("stream_level", int'(bus.FIFO_LEVEL), 0);

    // Backpressure
    bus.TX_READY = 0;
    log_q.delete();
    bus.DATA_VALID_IN = 1; bus.DATA_IN = 16'h1234;
    tick();
    bus.DATA_VALID_IN = 0;
    tick();
    for (int i = 0; i < 3; i++) begin
      check("bp_data", int'(bus.TX_DATA), 'h12);
      check("bp_valid", int'(bus.TX_VALID), 1);
      tick();
    end
    bus.TX_READY = 1;
    repeat (4) tick();
    exp_q = '{'h12, 'h34};
    expect_log("bp", exp_q);

    // Overflow
    bus.TX_READY = 0;
    log_q.delete();
    for (int w = 1; w <= 9; w++) begin
      bus.DATA_VALID_IN = 1; bus.DATA_IN = 16'(w);
      tick();
    end
    bus.DATA_VALID_IN = 0;
    tick();
    check("ovf_level", int'(bus.FIFO_LEVEL), 8);
    check("ovf_flag", int'(bus.OVERFLOW), 1);
    bus.TX_READY = 1;
    repeat (20) tick();
    exp_q.delete();
    for (int w = 1; w <= 8; w++) begin
      exp_q.push_back(0);
      exp_q.push_back(w);
    end
    expect_log("ovf_drain", exp_q);
    check("ovf_drain_level", int'(bus.FIFO_LEVEL), 0);
    bus.START_FLAG = 1;
    tick();
    bus.START_FLAG = 0;
    check("ovf_clear", int'(bus.OVERFLOW), 0);
    repeat (7) tick();

    // START_FLAG in the middle of a word frame
    log_q.delete();
    bus.DATA_VALID_IN = 1; bus.DATA_IN = 16'h1234;
    tick();
    bus.DATA_IN = 16'hABCD;
    tick();
    bus.DATA_VALID_IN = 0;
    n = 0;
    while (!(bus.TX_VALID && bus.TX_DATA == 8'h12) && n < 20) begin
      tick();
      n++;
    end
    check("mid_wait_timeout", int'(n < 20), 1);
    bus.START_FLAG = 1;
    tick();
    bus.START_FLAG = 0;
    repeat (12) tick();
    exp_q = '{'h12, 'h34, 'hA5, 'h00, 'h10, 'h42, 'h10, 'hAB, 'hCD};
    expect_log("mid", exp_q);

    // Asynchronous reset with a full FIFO and a frame in flight
    bus.TX_READY = 0;
    for (int w = 1; w <= 9; w++) begin
      bus.DATA_VALID_IN = 1; bus.DATA_IN = 16'(w);
      tick();
    end
    bus.DATA_VALID_IN = 0;
    tick();
    check("pre_rst_ovf", int'(bus.OVERFLOW), 1);
    #1 rst = 1'b1;
    #1;
    check("arst_valid", int'(bus.TX_VALID), 0);
    check("arst_level", int'(bus.FIFO_LEVEL), 0);
    check("arst_ovf", int'(bus.OVERFLOW), 0);
    tick();
    rst = 1'b0;

    // Random traffic
    ready_pct = 100;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc % 200 == 0) ready_pct = int'($urandom_range(20, 100));
      bus.EN            = ($urandom_range(0, 99) < 80);
      bus.DATA_VALID_IN = ($urandom_range(0, 99) < 50);
      bus.DATA_IN       = 16'($urandom);
      bus.DATA_HEAD_IN  = 26'($urandom);
      bus.START_FLAG    = ($urandom_range(0, 99) < 2);
      bus.TX_READY      = ($urandom_range(0, 99) < ready_pct);
      if ($urandom_range(0, 999) == 0) begin
        #1 rst = 1'b1;
        tick();
        rst = 1'b0;
      end else begin
        tick();
      end
    end

    bus.EN = 0; bus.DATA_VALID_IN = 0; bus.START_FLAG = 0; bus.TX_READY = 1;
    repeat (40) tick();
    check("final_idle", int'(bus.TX_VALID), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
